// File: rtl/block_scroller_pkg.sv
// Shared constants and helpers for the obstacle scroller: coordinate and
// shape-code widths, screen geometry, the LFSR step and the shape map.
package block_scroller_pkg;

   localparam int COORDINATE_LENGTH   = 10;   // x coordinates, 0..1023
   localparam int SHAPE_ENCODE_LENGTH = 4;    // shape code width
   localparam int BLOCK_WIDTH         = 40;   // obstacle width in pixels
   localparam int SCREEN_WIDTH        = 640;  // spawn x (right screen edge)
   localparam int NUM_SHAPES          = 11;   // legal shape codes 0..10
   localparam int LFSR_W              = 8;

   // Shape codes consumed by the in-block judge.
   localparam logic [SHAPE_ENCODE_LENGTH-1:0] SHAPE_0  = 4'd0;
   localparam logic [SHAPE_ENCODE_LENGTH-1:0] SHAPE_10 = 4'd10;

   // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // Fold a 4-bit random nibble onto the legal shape range by subtracting
   // NUM_SHAPES once; codes 11..15 land on 0..4.
   function automatic logic [SHAPE_ENCODE_LENGTH-1:0] shape_map(input logic [3:0] n);
      if (n >= 4'(NUM_SHAPES)) begin
         return n - 4'(NUM_SHAPES);
      end
      return n;
   endfunction

endpackage

// File: rtl/block_scroller_shape_lfsr.sv
// Pseudo-random shape source: 8-bit LFSR whose low nibble is mapped onto a
// legal shape code. The shape reflects the current LFSR value; the LFSR
// advances after use on each enabled cycle.
module shape_lfsr
   import block_scroller_pkg::*;
#(
   parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           i_enable,
   output logic [SHAPE_ENCODE_LENGTH-1:0] o_shape
);

   logic [LFSR_W-1:0] r_lfsr;

   // LFSR register: reseeded only by RST, stepped once per enabled cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_lfsr <= LFSR_SEED;
      end else if (i_enable) begin
         r_lfsr <= lfsr_step(r_lfsr);
      end
   end

   assign o_shape = shape_map(r_lfsr[3:0]);

endmodule

// File: rtl/block_scroller.sv
// Obstacle scroller: each frame event moves the valid obstacle slots left by
// SPEED, retires slots that would cross x=0, and spawns a new obstacle at the
// right screen edge once GAP pixels of scroll have accumulated and a slot is
// free. All outputs are registered.
module block_scroller
   import block_scroller_pkg::*;
#(
   parameter int                NUM_SLOTS = 4,
   parameter int                GAP       = 160,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
   input  logic                                     CLK,
   input  logic                                     RST,
   input  logic                                     FRAME_TICK,
   input  logic                                     RUN,
   input  logic                                     CLEAR,
   input  logic [3:0]                               SPEED,
   output logic [NUM_SLOTS*COORDINATE_LENGTH-1:0]   BLOCK_X_ALL,
   output logic [NUM_SLOTS*SHAPE_ENCODE_LENGTH-1:0] BLOCK_SHAPE_ALL,
   output logic [NUM_SLOTS-1:0]                     BLOCK_VALID,
   output logic                                     PASSED
);

   localparam int W = COORDINATE_LENGTH;
   localparam int S = SHAPE_ENCODE_LENGTH;
   localparam logic [W-1:0] GAP_INIT = W'(GAP);
   localparam logic [W-1:0] SPAWN_X  = W'(SCREEN_WIDTH);
   localparam logic [W-1:0] GAP_MAX  = {W{1'b1}};

   // Slot state.
   logic [W-1:0]         r_x     [NUM_SLOTS];
   logic [S-1:0]         r_shape [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_valid;
   logic [W-1:0]         r_gap;
   logic                 r_passed;

   // Next-state values computed for an update event.
   logic [W-1:0]         w_x_nxt     [NUM_SLOTS];
   logic [S-1:0]         w_shape_nxt [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] w_valid_nxt;
   logic [NUM_SLOTS-1:0] w_free_onehot;
   logic [W-1:0]         w_gap_nxt;
   logic [W-1:0]         w_gap_sat;
   logic [W:0]           w_gap_sum;
   logic [W-1:0]         w_speed;
   logic                 w_retired;
   logic                 w_spawn;
   logic                 w_event;
   logic [S-1:0]         w_shape;

   // CLEAR wins over FRAME_TICK; RUN=0 freezes everything.
   assign w_event = FRAME_TICK & RUN & ~CLEAR;
   assign w_speed = {{(W-4){1'b0}}, SPEED};

   shape_lfsr #(
      .LFSR_SEED (LFSR_SEED)
   ) u_shape_lfsr (
      .CLK      (CLK),
      .RST      (RST),
      .i_enable (w_event),
      .o_shape  (w_shape)
   );

   // Event next-state: move/retire, saturating gap growth, then spawn into
   // the lowest free slot (free status taken after retirement, so a slot
   // retired this event can be refilled; the new slot is not moved).
   always_comb begin : next_state
      logic l_found;
      w_x_nxt       = r_x;
      w_shape_nxt   = r_shape;
      w_valid_nxt   = r_valid;
      w_free_onehot = '0;
      w_retired     = 1'b0;
      w_spawn       = 1'b0;
      l_found       = 1'b0;

      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (r_valid[i]) begin
            if (r_x[i] >= w_speed) begin
               w_x_nxt[i] = r_x[i] - w_speed;
            end else begin
               w_valid_nxt[i] = 1'b0;
               w_retired      = 1'b1;
            end
         end
      end

      w_gap_sum = {1'b0, r_gap} + {1'b0, w_speed};
      w_gap_sat = w_gap_sum[W] ? GAP_MAX : w_gap_sum[W-1:0];
      w_gap_nxt = w_gap_sat;

      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!w_valid_nxt[i] && !l_found) begin
            w_free_onehot[i] = 1'b1;
            l_found          = 1'b1;
         end
      end

      // Without a free slot the spawn stays pending: gap keeps saturating.
      w_spawn = (w_gap_sat >= GAP_INIT) && l_found;
      if (w_spawn) begin
         w_gap_nxt = '0;
      end

      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (w_spawn && w_free_onehot[i]) begin
            w_x_nxt[i]     = SPAWN_X;
            w_shape_nxt[i] = w_shape;
            w_valid_nxt[i] = 1'b1;
         end
      end
   end

   // State register: RST and CLEAR empty the playfield (the LFSR keeps its
   // value on CLEAR), events commit the next state, PASSED is a single pulse.
   always_ff @(posedge CLK) begin
      if (RST || CLEAR) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_x[i]     <= '0;
            r_shape[i] <= SHAPE_0;
         end
         r_valid  <= '0;
         r_gap    <= GAP_INIT;
         r_passed <= 1'b0;
      end else if (w_event) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_x[i]     <= w_x_nxt[i];
            r_shape[i] <= w_shape_nxt[i];
         end
         r_valid  <= w_valid_nxt;
         r_gap    <= w_gap_nxt;
         r_passed <= w_retired;
      end else begin
         r_passed <= 1'b0;
      end
   end

   // Flatten slot registers onto the packed output buses.
   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
      assign BLOCK_X_ALL[g*W +: W]     = r_x[g];
      assign BLOCK_SHAPE_ALL[g*S +: S] = r_shape[g];
   end

   assign BLOCK_VALID = r_valid;
   assign PASSED      = r_passed;

endmodule
